// File: rtl/d_ip_m_pcrm_pkg.sv
// Shared types for the multi-domain PCRM sequencer: per-domain state encoding,
// the sequencer output bundle, its safe value and the state-to-output decode.
package d_ip_m_pcrm_pkg;

  typedef enum logic [3:0] {
    ST_OFF      = 4'd0,
    ST_PWR_UP   = 4'd1,
    ST_CLK_UP   = 4'd2,
    ST_ISO_REL  = 4'd3,
    ST_RST_REL  = 4'd4,
    ST_ON       = 4'd5,
    ST_RST_ASRT = 4'd6,
    ST_ISO_ASRT = 4'd7,
    ST_CLK_DN   = 4'd8,
    ST_PWR_DN   = 4'd9,
    ST_FAULT    = 4'd10
  } pcrm_state_e;

  typedef struct packed {
    logic pwr_en;
    logic clk_gate_en_b;
    logic vdd_iso_en_b;
    logic func_rst_b;
  } pcrm_outs_t;

  localparam pcrm_outs_t PCRM_SAFE_OUTS = '0;

  // Controls raised earlier in a sequence stay raised until the mirror step releases them.
  function automatic pcrm_outs_t pcrm_state_outs(input pcrm_state_e st);
    pcrm_outs_t o;
    o = PCRM_SAFE_OUTS;
    case (st)
      ST_PWR_UP, ST_CLK_DN: begin
        o.pwr_en = 1'b1;
      end
      ST_CLK_UP, ST_ISO_ASRT: begin
        o.pwr_en        = 1'b1;
        o.clk_gate_en_b = 1'b1;
      end
      ST_ISO_REL, ST_RST_REL, ST_RST_ASRT: begin
        o.pwr_en        = 1'b1;
        o.clk_gate_en_b = 1'b1;
        o.vdd_iso_en_b  = 1'b1;
      end
      ST_ON: begin
        o = '1;
      end
      default: begin
        o = PCRM_SAFE_OUTS;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/d_ip_m_pcrm_dom_fsm.sv
// One power domain's up/down sequencer with a shared hold/timeout counter.
// Outputs are registered from the next-state decode so they change on state entry.
module d_ip_m_pcrm_dom_fsm
  import d_ip_m_pcrm_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned RST_HOLD = 4,
  parameter int unsigned ACK_TO   = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic on_req,
  input  logic up_grant,
  input  logic pwr_ack,
  input  logic clk_ack,
  input  logic err_clr,
  output logic pwr_en,
  output logic clk_gate_en_b,
  output logic vdd_iso_en_b,
  output logic func_rst_b,
  output logic dom_on,
  output logic dom_err,
  output logic is_off,
  output logic is_pwr_up
);

  pcrm_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  pcrm_outs_t        outs_q, outs_d;
  logic              dom_on_q, dom_on_d;
  logic              err_q, err_d;
  logic              timeout;
  logic              hold_done;

  // An ack seen while the count equals ACK_TO still advances; only the cycle after faults.
  assign timeout   = (cnt_q == CNT_W'(ACK_TO));
  assign hold_done = (cnt_q == CNT_W'(RST_HOLD - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:      if (on_req && up_grant) state_d = ST_PWR_UP;
      ST_PWR_UP:   if (pwr_ack)            state_d = ST_CLK_UP;
                   else if (timeout)       state_d = ST_FAULT;
      ST_CLK_UP:   if (!clk_ack)           state_d = ST_ISO_REL;
                   else if (timeout)       state_d = ST_FAULT;
      ST_ISO_REL:                          state_d = ST_RST_REL;
      ST_RST_REL:  if (hold_done)          state_d = ST_ON;
      ST_ON:       if (!on_req)            state_d = ST_RST_ASRT;
      ST_RST_ASRT: if (hold_done)          state_d = ST_ISO_ASRT;
      ST_ISO_ASRT:                         state_d = ST_CLK_DN;
      ST_CLK_DN:   if (clk_ack)            state_d = ST_PWR_DN;
                   else if (timeout)       state_d = ST_FAULT;
      ST_PWR_DN:   if (!pwr_ack)           state_d = ST_OFF;
                   else if (timeout)       state_d = ST_FAULT;
      ST_FAULT:    if (err_clr && !on_req) state_d = ST_OFF;
      default:                             state_d = ST_OFF;
    endcase

    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

    outs_d   = pcrm_state_outs(state_d);
    dom_on_d = (state_d == ST_ON);

    // A new timeout wins over a simultaneous clear so the event is never lost.
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (state_d == ST_FAULT && state_q != ST_FAULT) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      outs_q   <= PCRM_SAFE_OUTS;
      dom_on_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      outs_q   <= outs_d;
      dom_on_q <= dom_on_d;
      err_q    <= err_d;
    end
  end

  assign pwr_en        = outs_q.pwr_en;
  assign clk_gate_en_b = outs_q.clk_gate_en_b;
  assign vdd_iso_en_b  = outs_q.vdd_iso_en_b;
  assign func_rst_b    = outs_q.func_rst_b;
  assign dom_on        = dom_on_q;
  assign dom_err       = err_q;
  assign is_off        = (state_q == ST_OFF);
  assign is_pwr_up     = (state_q == ST_PWR_UP);

endmodule

// File: rtl/d_ip_m_pcrm_ctrl_mc.sv
// Multi-domain power/clock/reset sequencer: replicates the per-domain FSM and
// arbitrates power-up so at most one domain is ramping its switch at a time.
module d_ip_m_pcrm_ctrl_mc
  import d_ip_m_pcrm_pkg::*;
#(
  parameter int unsigned NUM_DOM  = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned RST_HOLD = 4,
  parameter int unsigned ACK_TO   = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_DOM-1:0] dom_on_req,
  output logic [NUM_DOM-1:0] pwr_en,
  input  logic [NUM_DOM-1:0] pwr_gting_ack,
  output logic [NUM_DOM-1:0] clk_gate_en_b,
  input  logic [NUM_DOM-1:0] clk_gting_ack,
  output logic [NUM_DOM-1:0] vdd_iso_en_b,
  output logic [NUM_DOM-1:0] func_rst_b,
  output logic [NUM_DOM-1:0] dom_on,
  output logic [NUM_DOM-1:0] dom_err,
  input  logic [NUM_DOM-1:0] err_clr
);

  logic [NUM_DOM-1:0] is_off;
  logic [NUM_DOM-1:0] is_pwr_up;
  logic [NUM_DOM-1:0] up_grant;
  logic               found;

  // Inrush limit: lowest-index requester in OFF, and only while nobody is in PWR_UP.
  always_comb begin
    up_grant = '0;
    found    = 1'b0;
    if (!(|is_pwr_up)) begin
      for (int unsigned i = 0; i < NUM_DOM; i++) begin
        if (!found && is_off[i] && dom_on_req[i]) begin
          up_grant[i] = 1'b1;
          found       = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_DOM; g++) begin : g_dom
    d_ip_m_pcrm_dom_fsm #(
      .CNT_W    (CNT_W),
      .RST_HOLD (RST_HOLD),
      .ACK_TO   (ACK_TO)
    ) u_dom_fsm (
      .clk           (clk),
      .rst           (rst),
      .on_req        (dom_on_req[g]),
      .up_grant      (up_grant[g]),
      .pwr_ack       (pwr_gting_ack[g]),
      .clk_ack       (clk_gting_ack[g]),
      .err_clr       (err_clr[g]),
      .pwr_en        (pwr_en[g]),
      .clk_gate_en_b (clk_gate_en_b[g]),
      .vdd_iso_en_b  (vdd_iso_en_b[g]),
      .func_rst_b    (func_rst_b[g]),
      .dom_on        (dom_on[g]),
      .dom_err       (dom_err[g]),
      .is_off        (is_off[g]),
      .is_pwr_up     (is_pwr_up[g])
    );
  end

endmodule

// File: tb/tb_d_ip_m_pcrm_ctrl_mc.sv
// Directed bench for the multi-domain PCRM sequencer: a cycle table for one
// domain's up/down walk plus hand sequences for arbitration, timeout and reset.
module tb_d_ip_m_pcrm_ctrl_mc;

  localparam int unsigned NUM_DOM  = 4;
  localparam int unsigned RST_HOLD = 4;
  localparam int unsigned ACK_TO   = 200;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_DOM-1:0] dom_on_req;
  logic [NUM_DOM-1:0] pwr_en;
  logic [NUM_DOM-1:0] pwr_gting_ack;
  logic [NUM_DOM-1:0] clk_gate_en_b;
  logic [NUM_DOM-1:0] clk_gting_ack;
  logic [NUM_DOM-1:0] vdd_iso_en_b;
  logic [NUM_DOM-1:0] func_rst_b;
  logic [NUM_DOM-1:0] dom_on;
  logic [NUM_DOM-1:0] dom_err;
  logic [NUM_DOM-1:0] err_clr;
  logic [NUM_DOM-1:0] pwr_stuck;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Ideal switches/gates answer in the same cycle; pwr_stuck holds a switch unpowered.
  assign pwr_gting_ack = pwr_en & ~pwr_stuck;
  assign clk_gting_ack = ~clk_gate_en_b;

  d_ip_m_pcrm_ctrl_mc #(
    .NUM_DOM  (NUM_DOM),
    .CNT_W    (8),
    .RST_HOLD (RST_HOLD),
    .ACK_TO   (ACK_TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dom_on_req    (dom_on_req),
    .pwr_en        (pwr_en),
    .pwr_gting_ack (pwr_gting_ack),
    .clk_gate_en_b (clk_gate_en_b),
    .clk_gting_ack (clk_gting_ack),
    .vdd_iso_en_b  (vdd_iso_en_b),
    .func_rst_b    (func_rst_b),
    .dom_on        (dom_on),
    .dom_err       (dom_err),
    .err_clr       (err_clr)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] pwr;
    logic [3:0] clkb;
    logic [3:0] iso;
    logic [3:0] frst;
    logic [3:0] on;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] pwr,
                              input logic [3:0] clkb, input logic [3:0] iso,
                              input logic [3:0] frst, input logic [3:0] on);
    vec_t v;
    v.req = req; v.pwr = pwr; v.clkb = clkb; v.iso = iso; v.frst = frst; v.on = on;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pwr_en"},        32'(pwr_en),        32'h0);
    check({tag, "_clk_gate_en_b"}, 32'(clk_gate_en_b), 32'h0);
    check({tag, "_vdd_iso_en_b"},  32'(vdd_iso_en_b),  32'h0);
    check({tag, "_func_rst_b"},    32'(func_rst_b),    32'h0);
    check({tag, "_dom_on"},        32'(dom_on),        32'h0);
  endtask

  task automatic do_reset();
    dom_on_req = '0;
    err_clr    = '0;
    pwr_stuck  = '0;
    rst        = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Domain 0 alone; entry k drives cycle k and predicts outputs in cycle k+1.
    vecs[0]  = mk(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[1]  = mk(4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    vecs[2]  = mk(4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
    vecs[3]  = mk(4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
    vecs[4]  = mk(4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
    vecs[5]  = mk(4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
    vecs[6]  = mk(4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
    vecs[7]  = mk(4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1);
    vecs[8]  = mk(4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1);
    vecs[9]  = mk(4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
    vecs[10] = mk(4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
    vecs[11] = mk(4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
    vecs[12] = mk(4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
    vecs[13] = mk(4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    vecs[14] = mk(4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[15] = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[16] = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[17] = mk(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);

    rst        = 1'b0;
    dom_on_req = '0;
    err_clr    = '0;
    pwr_stuck  = '0;
    #2 rst = 1'b1;
    #1;
    check_all_zero("reset");
    check("reset_dom_err", 32'(dom_err), 32'h0);

    // Table: single up then down sequence.
    do_reset();
    for (int k = 0; k < 18; k++) begin
      dom_on_req = vecs[k].req;
      step();
      check($sformatf("vec%0d_pwr_en", k),        32'(pwr_en),        32'(vecs[k].pwr));
      check($sformatf("vec%0d_clk_gate_en_b", k), 32'(clk_gate_en_b), 32'(vecs[k].clkb));
      check($sformatf("vec%0d_vdd_iso_en_b", k),  32'(vdd_iso_en_b),  32'(vecs[k].iso));
      check($sformatf("vec%0d_func_rst_b", k),    32'(func_rst_b),    32'(vecs[k].frst));
      check($sformatf("vec%0d_dom_on", k),        32'(dom_on),        32'(vecs[k].on));
      check($sformatf("vec%0d_dom_err", k),       32'(dom_err),       32'h0);
    end

    // All four request together: grants step through the domains two cycles apart.
    do_reset();
    dom_on_req = 4'hF;
    for (int c = 1; c <= 14; c++) begin
      logic [3:0] exp_pwr, exp_pu, exp_on;
      step();
      exp_pwr = '0;
      exp_pu  = '0;
      exp_on  = '0;
      for (int i = 0; i < 4; i++) begin
        if (c >= 1 + 2 * i) exp_pwr[i] = 1'b1;
        if (c == 1 + 2 * i) exp_pu[i]  = 1'b1;
        if (c >= 8 + 2 * i) exp_on[i]  = 1'b1;
      end
      check($sformatf("inrush_c%0d_pwr_en", c),  32'(pwr_en), 32'(exp_pwr));
      check($sformatf("inrush_c%0d_pwr_up", c),  32'(pwr_en & ~clk_gate_en_b), 32'(exp_pu));
      check($sformatf("inrush_c%0d_dom_on", c),  32'(dom_on), 32'(exp_on));
    end

    // Ack arriving exactly when the count reaches ACK_TO still advances.
    do_reset();
    pwr_stuck  = 4'h1;
    dom_on_req = 4'h1;
    step();
    repeat (ACK_TO) step();
    check("to_edge_pwr_en", 32'(pwr_en), 32'h1);
    pwr_stuck = 4'h0;
    step();
    check("to_edge_clk_gate_en_b", 32'(clk_gate_en_b), 32'h1);
    check("to_edge_dom_err",       32'(dom_err),       32'h0);

    // Stuck power ack: FAULT after ACK_TO+1 cycles in PWR_UP; domain 1 waits behind it.
    do_reset();
    pwr_stuck  = 4'h1;
    dom_on_req = 4'h3;
    step();
    check("fault_c1_pwr_en", 32'(pwr_en), 32'h1);
    repeat (ACK_TO) step();
    check("fault_last_wait_pwr_en",  32'(pwr_en),  32'h1);
    check("fault_last_wait_dom_err", 32'(dom_err), 32'h0);
    step();
    check("fault_entry_pwr_en",  32'(pwr_en),  32'h0);
    check("fault_entry_dom_err", 32'(dom_err), 32'h1);
    step();
    check("fault_d1_granted_pwr_en", 32'(pwr_en),  32'h2);
    check("fault_sticky_dom_err",    32'(dom_err), 32'h1);
    pwr_stuck  = 4'h0;
    dom_on_req = 4'h2;
    err_clr    = 4'h1;
    step();
    check("fault_clr_dom_err", 32'(dom_err), 32'h0);
    check("fault_clr_pwr_en0", 32'(pwr_en[0]), 32'h0);
    err_clr    = 4'h0;
    dom_on_req = 4'h3;
    step();
    check("fault_off_regrant_pwr_en0", 32'(pwr_en[0]), 32'h1);

    // Request dropped in CLK_UP: up sequence completes, then a full down sequence.
    do_reset();
    dom_on_req = 4'h1;
    step();
    step();
    check("drop_clk_up_clk_gate_en_b", 32'(clk_gate_en_b), 32'h1);
    dom_on_req = 4'h0;
    repeat (6) step();
    check("drop_on_dom_on",      32'(dom_on),     32'h1);
    check("drop_on_func_rst_b",  32'(func_rst_b), 32'h1);
    step();
    check("drop_rst_asrt_func_rst_b", 32'(func_rst_b),   32'h0);
    check("drop_rst_asrt_iso",        32'(vdd_iso_en_b), 32'h1);
    repeat (5) step();
    check("drop_clk_dn_clk_gate_en_b", 32'(clk_gate_en_b), 32'h0);
    check("drop_clk_dn_pwr_en",        32'(pwr_en),        32'h1);
    step();
    check("drop_pwr_dn_pwr_en", 32'(pwr_en), 32'h0);
    step();
    dom_on_req = 4'h1;
    step();
    check("drop_off_regrant_pwr_en", 32'(pwr_en), 32'h1);

    // Asynchronous reset while in RST_REL.
    do_reset();
    dom_on_req = 4'h1;
    repeat (5) step();
    check("arst_pre_iso", 32'(vdd_iso_en_b), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("arst_async");
    @(posedge clk);
    #1;
    rst        = 1'b0;
    dom_on_req = 4'h0;
    step();
    check_all_zero("arst_after");
    dom_on_req = 4'h1;
    step();
    check("arst_off_regrant_pwr_en", 32'(pwr_en), 32'h1);
    check("arst_off_regrant_clk",    32'(clk_gate_en_b), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
